// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO drain stream stage: skid buffer states and the beat layout.
package fifo_stream_pkg;

  localparam int DEF_BITS = 32;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;

  typedef struct packed {
    logic                last;
    logic [DEF_BITS-1:0] data;
  } beat_t;

endpackage

// File: rtl/fifo_stream_out_if.sv
// FIFO pop side and valid/ready stream side of the drain stage, bundled as one interface.
interface fifo_stream_out_if
  import fifo_stream_pkg::*;
#(
  parameter int BITS = DEF_BITS
) ();

  logic            pndng;
  logic [BITS-1:0] fifo_dout;
  logic            pop;
  logic [BITS-1:0] m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready;

  modport master (
    input  pndng, fifo_dout, m_ready,
    output pop, m_data, m_valid, m_last
  );

  modport slave (
    output pndng, fifo_dout, m_ready,
    input  pop, m_data, m_valid, m_last
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: main register drives the stream, skid catches one extra word
// so the upstream pop never waits on downstream ready.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS:0]   in_beat,
  output logic            space_ok,
  output logic [BITS-1:0] m_data,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready
);

  skid_state_t   r_state;
  logic [BITS:0] r_main;
  logic [BITS:0] r_skid;
  logic          r_valid;
  logic          w_xfer;

  assign w_xfer   = r_valid & m_ready;
  assign space_ok = (r_state != ST_TWO);
  assign m_valid  = r_valid;
  assign m_data   = r_main[BITS-1:0];
  assign m_last   = r_main[BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (in_valid) begin
            r_main  <= in_beat;
            r_valid <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_valid && !w_xfer) begin
            r_skid  <= in_beat;
            r_state <= ST_TWO;
          end else if (in_valid && w_xfer) begin
            r_main  <= in_beat;
          end else if (w_xfer) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Upstream is stalled here, so only a downstream accept can move things.
          if (w_xfer) begin
            r_main  <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_out.sv
// FIFO drain stage: pops the FIFO into a registered valid/ready stream, tags burst-final
// beats with m_last and keeps accepted-word and completed-burst counters.
module fifo_stream_out
  import fifo_stream_pkg::*;
#(
  parameter int BITS      = DEF_BITS,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_stream_out_if.master    bus,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     burst_cnt
);

  localparam int               IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  logic             w_space_ok;
  logic             w_pop;
  logic             w_tag_last;
  logic             w_xfer;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_burst_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Pop depends only on registered buffer state, never on m_ready.
  assign w_pop      = enable & bus.pndng & w_space_ok & ~rst;
  assign w_tag_last = (r_idx == LAST_IDX);
  assign w_xfer     = bus.m_valid & bus.m_ready;
  assign bus.pop    = w_pop;
  assign word_cnt   = r_word_cnt;
  assign burst_cnt  = r_burst_cnt;

  stream_skid_buf #(
    .BITS (BITS)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (w_pop),
    .in_beat  ({w_tag_last, bus.fifo_dout}),
    .space_ok (w_space_ok),
    .m_data   (bus.m_data),
    .m_valid  (bus.m_valid),
    .m_last   (bus.m_last),
    .m_ready  (bus.m_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_word_cnt  <= '0;
      r_burst_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_idx <= w_tag_last ? '0 : r_idx + IDX_W'(1);
      end
      if (w_xfer) begin
        r_word_cnt <= sat_inc(r_word_cnt);
        if (bus.m_last) begin
          r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: queue-based FIFO and stream scoreboard, two builds (BURST_LEN 4 / 1).
module tb_fifo_stream_out;
  localparam int BITS = 32;
  localparam int BL   = 4;
  localparam int CW   = 16;
  localparam int CW2  = 4;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [CW-1:0]  word_cnt, burst_cnt;
  logic [CW2-1:0] word_cnt2, burst_cnt2;

  fifo_stream_out_if #(.BITS(BITS)) bus ();
  fifo_stream_out_if #(.BITS(BITS)) bus2 ();

  fifo_stream_out #(.BITS(BITS), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .word_cnt(word_cnt), .burst_cnt(burst_cnt));

  fifo_stream_out #(.BITS(BITS), .BURST_LEN(1), .CNT_W(CW2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus2),
    .word_cnt(word_cnt2), .burst_cnt(burst_cnt2));

  always #5 clk = ~clk;

  logic [BITS-1:0] fq[$], fq2[$];
  logic [BITS:0]   eq[$], eq2[$];
  logic [BITS:0]   got_q[$], got2_q[$];
  logic            xlog[$];
  int unsigned     idx_m;
  longint unsigned wc_m, bc_m, wc2_m, bc2_m;
  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  function automatic int gap_count();
    int f0 = -1;
    int l0 = -1;
    int g  = 0;
    foreach (xlog[i]) if (xlog[i]) begin
      if (f0 < 0) f0 = i;
      l0 = i;
    end
    if (f0 >= 0) for (int i = f0; i <= l0; i++) if (!xlog[i]) g++;
    return g;
  endfunction

  task automatic push(input logic [BITS-1:0] d);
    fq.push_back(d);
    bus.pndng     = 1'b1;
    bus.fifo_dout = fq[0];
  endtask

  task automatic push2(input logic [BITS-1:0] d);
    fq2.push_back(d);
    bus2.pndng     = 1'b1;
    bus2.fifo_dout = fq2[0];
  endtask

  task automatic tick();
    logic s_rst, s_pop, s_xfer, s_pop2, s_xfer2, e_pop, e_pop2;
    logic [BITS:0] s_beat, s_beat2, e;
    #1;
    s_rst   = rst;
    s_pop   = bus.pop;
    s_xfer  = bus.m_valid & bus.m_ready;
    s_beat  = {bus.m_last, bus.m_data};
    s_pop2  = bus2.pop;
    s_xfer2 = bus2.m_valid & bus2.m_ready;
    s_beat2 = {bus2.m_last, bus2.m_data};
    e_pop   = enable && fq.size() != 0 && eq.size() < 2 && !rst;
    e_pop2  = enable && fq2.size() != 0 && eq2.size() < 2 && !rst;
    total++;
    if (s_pop !== e_pop) begin
      bad++;
      $display("FAIL pop_rule: pop=%b expected %b (held=%0d fifo=%0d)", s_pop, e_pop, eq.size(), fq.size());
    end
    total++;
    if (s_pop2 !== e_pop2) begin
      bad++;
      $display("FAIL pop_rule2: pop=%b expected %b", s_pop2, e_pop2);
    end
    @(posedge clk);
    #1;
    if (s_rst) begin
      eq.delete(); eq2.delete();
      idx_m = 0; wc_m = 0; bc_m = 0; wc2_m = 0; bc2_m = 0;
    end else begin
      xlog.push_back(s_xfer);
      if (s_xfer) begin
        e = (eq.size() != 0) ? eq.pop_front() : 'x;
        total++;
        if (s_beat !== e) begin
          bad++;
          $display("FAIL beat: got %h expected %h", s_beat, e);
        end
        got_q.push_back(s_beat);
        if (wc_m != (64'd1 << CW) - 1) wc_m++;
        if (s_beat[BITS]) bc_m = (bc_m + 1) % (64'd1 << CW);
      end
      if (s_pop) begin
        eq.push_back({(idx_m == BL - 1), fq.pop_front()});
        idx_m = (idx_m + 1) % BL;
        n_pop++;
      end
      if (s_xfer2) begin
        e = (eq2.size() != 0) ? eq2.pop_front() : 'x;
        total++;
        if (s_beat2 !== e) begin
          bad++;
          $display("FAIL beat2: got %h expected %h", s_beat2, e);
        end
        got2_q.push_back(s_beat2);
        if (wc2_m != (64'd1 << CW2) - 1) wc2_m++;
        if (s_beat2[BITS]) bc2_m = (bc2_m + 1) % (64'd1 << CW2);
      end
      if (s_pop2) eq2.push_back({1'b1, fq2.pop_front()});
    end
    total++;
    if (bus.m_valid !== (eq.size() != 0)) begin
      bad++;
      $display("FAIL valid: m_valid=%b expected %b", bus.m_valid, eq.size() != 0);
    end
    if (eq.size() != 0) begin
      total++;
      if ({bus.m_last, bus.m_data} !== eq[0]) begin
        bad++;
        $display("FAIL head: got %h expected %h", {bus.m_last, bus.m_data}, eq[0]);
      end
    end
    total++;
    if (word_cnt !== CW'(wc_m) || burst_cnt !== CW'(bc_m)) begin
      bad++;
      $display("FAIL counters: word=%0d burst=%0d expected %0d %0d", word_cnt, burst_cnt, wc_m, bc_m);
    end
    total++;
    if (bus2.m_valid !== (eq2.size() != 0) || word_cnt2 !== CW2'(wc2_m) || burst_cnt2 !== CW2'(bc2_m)) begin
      bad++;
      $display("FAIL status2: valid=%b word=%0d burst=%0d expected %b %0d %0d",
               bus2.m_valid, word_cnt2, burst_cnt2, eq2.size() != 0, wc2_m, bc2_m);
    end
    bus.pndng      = (fq.size() != 0);
    bus.fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    bus2.pndng     = (fq2.size() != 0);
    bus2.fifo_dout = (fq2.size() != 0) ? fq2[0] : '0;
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((fq.size() != 0 || eq.size() != 0 || fq2.size() != 0 || eq2.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    total++;
    if (fq.size() != 0 || eq.size() != 0 || fq2.size() != 0 || eq2.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: still %0d/%0d words after %0d cycles", fq.size(), eq.size(), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete(); got2_q.delete(); xlog.delete();
  endtask

  task automatic test_reset();
    int p0;
    enable = 1'b1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hA0 + i);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0 = n_pop;
    tick(); tick(); tick();
    total++;
    if (n_pop - p0 != 2) begin
      bad++;
      $display("FAIL reset_prefill_pops: got %0d expected 2", n_pop - p0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b last=%b data=%h expected 0 0 0", bus.m_valid, bus.m_last, bus.m_data);
    end
    total++;
    if (word_cnt !== '0 || burst_cnt !== '0) begin
      bad++;
      $display("FAIL reset_counters: word=%0d burst=%0d expected 0 0", word_cnt, burst_cnt);
    end
    got_q.delete();
    push(32'hA5);
    bus.m_ready = 1'b1;
    drain(50);
    total++;
    if (got_q.size() != 4 || got_q[0] !== {1'b0, 32'hA2} || got_q[3] !== {1'b1, 32'hA5}) begin
      bad++;
      $display("FAIL reset_restart: n=%0d first=%h fourth=%h expected 4 0a2 1a5", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 'x, (got_q.size() > 3) ? got_q[3] : 'x);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(i);
    drain(30);
    total++;
    if (got_q.size() != 8) begin
      bad++;
      $display("FAIL stream_count: got %0d expected 8", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== {((i % 4) == 3), 32'(i + 1)}) begin
        bad++;
        $display("FAIL stream_beat%0d: got %h expected %h", i, got_q[i], {((i % 4) == 3), 32'(i + 1)});
      end
    end
    total++;
    if (word_cnt !== 16'd8 || burst_cnt !== 16'd2) begin
      bad++;
      $display("FAIL stream_counters: word=%0d burst=%0d expected 8 2", word_cnt, burst_cnt);
    end
    total++;
    if (gap_count() != 0) begin
      bad++;
      $display("FAIL stream_gaps: got %0d expected 0", gap_count());
    end
  endtask

  task automatic test_backpressure();
    int p0;
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    p0 = n_pop;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (n_pop - p0 != 2 || fq.size() != 14 || bus.pndng !== 1'b1) begin
      bad++;
      $display("FAIL bp_stall: pops=%0d left=%0d pndng=%b expected 2 14 1", n_pop - p0, fq.size(), bus.pndng);
    end
    total++;
    if (bus.m_data !== 32'h100 || bus.m_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold: data=%h valid=%b expected 100 1", bus.m_data, bus.m_valid);
    end
    xlog.delete();
    bus.m_ready = 1'b1;
    drain(60);
    total++;
    if (got_q.size() != 16 || gap_count() != 0) begin
      bad++;
      $display("FAIL bp_drain: n=%0d gaps=%0d expected 16 0", got_q.size(), gap_count());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i][BITS-1:0] !== 32'h100 + i) begin
        bad++;
        $display("FAIL bp_order%0d: got %h expected %h", i, got_q[i][BITS-1:0], 32'h100 + i);
      end
    end
  endtask

  task automatic test_random();
    logic [BITS-1:0] sent[$];
    int n = 0;
    int mism = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      sent.push_back($urandom);
      push(sent[i]);
    end
    while ((fq.size() != 0 || eq.size() != 0) && n < 1000) begin
      bus.m_ready = $urandom_range(0, 1);
      tick();
      n++;
    end
    bus.m_ready = 1'b1;
    total++;
    if (got_q.size() != 100) begin
      bad++;
      $display("FAIL rand_count: got %0d expected 100 after %0d cycles", got_q.size(), n);
    end
    foreach (got_q[i]) if (i < 100 && got_q[i][BITS-1:0] !== sent[i]) mism++;
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL rand_order: %0d words out of place, expected 0", mism);
    end
    total++;
    if (word_cnt !== 16'd100 || burst_cnt !== 16'd25) begin
      bad++;
      $display("FAIL rand_counters: word=%0d burst=%0d expected 100 25", word_cnt, burst_cnt);
    end
  endtask

  task automatic test_enable_pause();
    int p0;
    int n = 0;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h200 + i);
    p0 = n_pop;
    while (n_pop - p0 < 2 && n < 10) begin
      tick();
      n++;
    end
    enable = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (n_pop != p0 || bus.m_valid !== 1'b0) begin
      bad++;
      $display("FAIL pause_pops: pops=%0d valid=%b expected 0 0", n_pop - p0, bus.m_valid);
    end
    enable = 1'b1;
    drain(40);
    total++;
    if (got_q.size() != 8 || got_q[1][BITS] !== 1'b0 || got_q[3] !== {1'b1, 32'h203} || got_q[7][BITS] !== 1'b1) begin
      bad++;
      $display("FAIL pause_last: n=%0d beat4=%h expected 8 1_00000203", got_q.size(),
               (got_q.size() > 3) ? got_q[3] : 'x);
    end
  endtask

  task automatic test_burst1();
    do_reset();
    for (int i = 0; i < 3; i++) push2(32'h300 + i);
    drain(20);
    total++;
    if (got2_q.size() != 3 || burst_cnt2 !== 4'd3 || got2_q[0][BITS] !== 1'b1 || got2_q[2][BITS] !== 1'b1) begin
      bad++;
      $display("FAIL b1_three: n=%0d burst=%0d expected 3 3", got2_q.size(), burst_cnt2);
    end
    for (int i = 3; i < 20; i++) push2(32'h300 + i);
    drain(60);
    total++;
    if (word_cnt2 !== 4'd15 || burst_cnt2 !== 4'd4 || got2_q.size() != 20) begin
      bad++;
      $display("FAIL b1_saturate: word=%0d burst=%0d n=%0d expected 15 4 20", word_cnt2, burst_cnt2, got2_q.size());
    end
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    bus.pndng      = 1'b0;
    bus.fifo_dout  = '0;
    bus.m_ready    = 1'b0;
    bus2.pndng     = 1'b0;
    bus2.fifo_dout = '0;
    bus2.m_ready   = 1'b1;
    idx_m = 0; wc_m = 0; bc_m = 0; wc2_m = 0; bc2_m = 0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_enable_pause();
    test_burst1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_out.md
Name: fifo_stream_out

Overview:
Drain stage sitting directly downstream of fifo_flops. It pops words from the FIFO's push/pop/pndng interface and re-presents them as a registered valid/ready stream with a burst-delimiting last flag. A 2-entry skid buffer means the FIFO pop never depends combinationally on downstream ready. Status counters expose transferred words and completed bursts.

Parameters:
BITS, 32, data width; matches FIFO width.
BURST_LEN, 4, words per burst; m_last marks the final beat; legal range 1..256.
CNT_W, 16, width of the status counters.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  permits popping from the FIFO; buffered words drain regardless.
pndng  input  1  FIFO non-empty; fifo_dout holds the head word while high.
fifo_dout  input  BITS  FIFO head word (first-word-fall-through).
pop  output  1  FIFO pop strobe; consumes the head at the clock edge.
m_data  output  BITS  stream data, registered.
m_valid  output  1  stream valid.
m_last  output  1  final beat of the current burst, qualified by m_valid.
m_ready  input  1  downstream accepts the beat when m_valid & m_ready.
word_cnt  output  CNT_W  accepted beats; saturates at all-ones.
burst_cnt  output  CNT_W  accepted beats carrying m_last; wraps.

Behaviour:
- Reset (rst=1 at an edge): m_valid=0, m_last=0, m_data=0, pop=0, word_cnt=0, burst_cnt=0, beat index=0, state=ST_EMPTY. Buffered words are discarded. pop is forced 0 combinationally while rst=1.
- Storage: a main register (drives m_*) and a skid register, each holding {data, last}.
- States:
  - ST_EMPTY: main empty, skid empty.
  - ST_ONE: main full, skid empty.
  - ST_TWO: main full, skid full.
- pop = enable & pndng & (state != ST_TWO) & !rst. It is a function of registered state and inputs only; there is no m_ready-to-pop path.
- xfer = m_valid & m_ready.
- Transitions:
  - ST_EMPTY: pop -> ST_ONE; the word is loaded into main.
  - ST_ONE:
    - pop & !xfer -> ST_TWO; the word goes to skid.
    - pop & xfer -> ST_ONE; main reloads from the FIFO word.
    - !pop & xfer -> ST_EMPTY.
    - otherwise hold.
  - ST_TWO:
    - xfer -> ST_ONE; skid moves to main.
    - otherwise hold. pop=0 in this state.
- Latency: with main empty, a word popped at edge k is valid on m_data/m_valid after edge k. Sustained throughput is 1 word/cycle when m_ready=1 and pndng=1.
- Stability: while m_valid & !m_ready, m_data and m_last hold unchanged.
- Ordering: strict FIFO order; no duplication or loss.
- Last flag:
  - A beat index counter 0..BURST_LEN-1 advances on every pop. The popped word is tagged last when index==BURST_LEN-1, and the index then wraps to 0.
  - BURST_LEN=1 tags every word.
- enable deasserted mid-burst: popping stops and the beat index is retained, so the burst resumes correctly when enable returns. Buffered words still drain.
- FIFO empty (pndng=0): no pop. m_valid drops after the main word transfers.
- Counters:
  - word_cnt +1 per xfer, saturating at 2^CNT_W-1.
  - burst_cnt +1 per xfer with m_last=1, wrapping modulo 2^CNT_W.
- Reset asserted mid-operation, including mid-burst: same as the reset row above on that edge; the next burst starts at index 0.

Decomposition:
- Package fifo_stream_pkg:
  - typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;
  - packed struct beat_t {logic last; logic [BITS-1:0] data;} parameterised via localparam;
  - default BITS constant.
- Sub-module stream_skid_buf holds the 2-entry buffer and state machine; it has in_valid (=pop), in_beat, space_ok and the m_* outputs.
- The top level holds the pop logic, beat index and counters.

Test Plan:
- Reset mid-stream: FIFO holds 5 words, pop 2, assert rst for 1 cycle -> m_valid=0, counters=0, buffer empty. After release the next word is tagged index 0.
- Streaming: push 0x1..0x8 into the FIFO, enable=1, m_ready=1 -> m_data 0x1..0x8 on consecutive cycles. m_last is 1 on 0x4 and 0x8. word_cnt=8, burst_cnt=2.
- Backpressure: fill FIFO with 16 words, m_ready=0 -> exactly 2 pops, then pop=0, FIFO pndng stays 1 (14 left), and m_data holds word 1 stable. Then m_ready=1 -> all 16 words arrive in order with no gap after the first.
- Random m_ready (50%) over 100 words -> scoreboard matches order, word_cnt=100, burst_cnt=25. pop is never asserted in ST_TWO.
- enable deasserted after word 2 of a burst for 10 cycles -> no pops during that window. On resume, m_last lands on the 4th word of that burst.
- BURST_LEN=1 build, 3 words -> m_last=1 on every beat, burst_cnt=3. CNT_W=4 with 20 words -> word_cnt saturates at 15.
